reg_bus_arbiter: RTL and testbench

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

---
 rtl/reg_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_reg_bus_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// Two-requester arbiter onto a shared one-hot-select 16-bit register bus; one transaction in flight.
// Define REG_ARB_RR_EN for round-robin contention handling; otherwise m0 has fixed priority.
module reg_bus_arbiter #(
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            m0_req_valid,
  output logic            m0_req_ready,
  input  logic            m0_req_wr,
  input  logic [AW-1:0]   m0_req_addr,
  input  logic [15:0]     m0_req_wdata,
  output logic            m0_rsp_valid,
  output logic [15:0]     m0_rsp_rdata,
  output logic            m0_rsp_err,
  input  logic            m1_req_valid,
  output logic            m1_req_ready,
  input  logic            m1_req_wr,
  input  logic [AW-1:0]   m1_req_addr,
  input  logic [15:0]     m1_req_wdata,
  output logic            m1_rsp_valid,
  output logic [15:0]     m1_rsp_rdata,
  output logic            m1_rsp_err,
  output logic [NREG-1:0] sel,
  output logic            wr,
  output logic [15:0]     wdata,
  input  logic [15:0]     rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
  } req_t;

  state_t      state, state_nx;
  req_t        cmd;
  logic        owner;
  logic [15:0] cap;
  logic        g0, g1, hs, in_range;

`ifdef REG_ARB_RR_EN
  logic last;  // 1 = m1 granted most recently

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (state == IDLE) begin
      if (m0_req_valid && m1_req_valid) begin
        g0 = last;
        g1 = ~last;
      end else begin
        g0 = m0_req_valid;
        g1 = m1_req_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   last <= 1'b1;
    else if (hs) last <= g1;
  end
`else
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (state == IDLE) begin
      g0 = m0_req_valid;
      g1 = m1_req_valid & ~m0_req_valid;
    end
  end
`endif

  assign m0_req_ready = g0;
  assign m1_req_ready = g1;
  assign hs           = g0 | g1;
  assign in_range     = (int'(cmd.addr) < NREG);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cmd   <= '0;
      owner <= 1'b0;
      cap   <= '0;
    end else begin
      state <= state_nx;
      if (hs) begin
        owner <= g1;
        cmd   <= g1 ? req_t'{m1_req_wr, m1_req_addr, m1_req_wdata}
                    : req_t'{m0_req_wr, m0_req_addr, m0_req_wdata};
      end
      if (state == ACCESS && !cmd.wr && in_range) cap <= rdata;
    end
  end

  // Bus outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    sel   = '0;
    wr    = 1'b0;
    wdata = '0;
    if (state == ACCESS) begin
      wdata = cmd.wdata;
      if (in_range) begin
        wr = cmd.wr;
        for (int i = 0; i < NREG; i++) sel[i] = (cmd.addr == AW'(i));
      end
    end
  end

  logic        rsp;
  logic [15:0] rsp_data;

  assign rsp      = (state == RESP);
  assign rsp_data = (!cmd.wr && in_range) ? cap : 16'h0;

  assign m0_rsp_valid = rsp & ~owner;
  assign m1_rsp_valid = rsp &  owner;
  assign m0_rsp_rdata = m0_rsp_valid ? rsp_data : 16'h0;
  assign m1_rsp_rdata = m1_rsp_valid ? rsp_data : 16'h0;
  assign m0_rsp_err   = m0_rsp_valid & ~in_range;
  assign m1_rsp_err   = m1_rsp_valid & ~in_range;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: 4-register bus with a behavioural register file,
// plus an NREG=3 instance for the out-of-range error path.
module tb_reg_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        m0_req_valid, m0_req_ready, m0_req_wr, m0_rsp_valid, m0_rsp_err;
  logic [1:0]  m0_req_addr;
  logic [15:0] m0_req_wdata, m0_rsp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_req_wr, m1_rsp_valid, m1_rsp_err;
  logic [1:0]  m1_req_addr;
  logic [15:0] m1_req_wdata, m1_rsp_rdata;
  logic [3:0]  sel;
  logic        wr;
  logic [15:0] wdata, rdata;

  reg_bus_arbiter #(.NREG(4), .AW(2)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_wr(m0_req_wr),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_wr(m1_req_wr),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .sel(sel), .wr(wr), .wdata(wdata), .rdata(rdata)
  );

  // NREG=3 instance; its bus reads a constant so a leak of rdata into an error response shows.
  logic        e_valid, e_ready, e_rsp_valid, e_err, e_wr;
  logic [1:0]  e_addr;
  logic [15:0] e_rsp_rdata, e_wdata;
  logic        f_valid, f_ready, f_rsp_valid, f_err;
  logic [1:0]  f_addr;
  logic [15:0] f_rsp_rdata;
  logic [2:0]  e_sel;
  logic        e_bus_wr;
  logic [15:0] e_bus_wdata;
  logic [15:0] e_bus_rdata;

  assign e_bus_rdata = 16'hA5A5;

  reg_bus_arbiter #(.NREG(3), .AW(2)) dut3 (
    .clk(clk), .rstn(rstn),
    .m0_req_valid(e_valid), .m0_req_ready(e_ready), .m0_req_wr(e_wr),
    .m0_req_addr(e_addr), .m0_req_wdata(e_wdata), .m0_rsp_valid(e_rsp_valid),
    .m0_rsp_rdata(e_rsp_rdata), .m0_rsp_err(e_err),
    .m1_req_valid(f_valid), .m1_req_ready(f_ready), .m1_req_wr(1'b0),
    .m1_req_addr(f_addr), .m1_req_wdata(16'h0), .m1_rsp_valid(f_rsp_valid),
    .m1_rsp_rdata(f_rsp_rdata), .m1_rsp_err(f_err),
    .sel(e_sel), .wr(e_bus_wr), .wdata(e_bus_wdata), .rdata(e_bus_rdata)
  );

  // Register file on the shared bus.
  logic [15:0] regs [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  always @(posedge clk)
    if (wr)
      for (int i = 0; i < 4; i++)
        if (sel[i]) regs[i] <= wdata;

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++)
      if (sel[i] && !wr) rdata = rdata | regs[i];
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One transaction on the 4-register DUT, checking ready, ACCESS-cycle bus and RESP pulse.
  task automatic txn(input bit m, input bit w, input logic [1:0] a, input logic [15:0] d,
                     input logic [3:0] esel, input logic [15:0] erd);
    @(negedge clk);
    if (!m) begin
      m0_req_valid = 1'b1; m0_req_wr = w; m0_req_addr = a; m0_req_wdata = d;
    end else begin
      m1_req_valid = 1'b1; m1_req_wr = w; m1_req_addr = a; m1_req_wdata = d;
    end
    #1;
    chk("ready", {30'd0, m1_req_ready, m0_req_ready}, m ? 32'd2 : 32'd1);
    @(negedge clk);
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    m0_req_wdata = 16'hDEAD; m1_req_wdata = 16'hDEAD;
    chk("access_bus", {11'd0, sel, wr, wdata}, {11'd0, esel, w, d});
    chk("access_norsp", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rsp_valid", {30'd0, m1_rsp_valid, m0_rsp_valid}, m ? 32'd2 : 32'd1);
    chk("rsp_data", {m1_rsp_rdata, m0_rsp_rdata}, m ? {erd, 16'h0} : {16'h0, erd});
    chk("rsp_err", {30'd0, m1_rsp_err, m0_rsp_err}, 32'd0);
    chk("rsp_bus_idle", {11'd0, sel, wr, wdata}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_ctl", {21'd0, sel, wr, m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid,
                    m0_rsp_err, m1_rsp_err}, 32'd0);
    chk("rst_data", {wdata, m0_rsp_rdata | m1_rsp_rdata}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  int exp_g [4];
  int ng;

  initial begin
`ifdef REG_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    rstn = 1'b0;
    m0_req_valid = 0; m0_req_wr = 0; m0_req_addr = 0; m0_req_wdata = 0;
    m1_req_valid = 0; m1_req_wr = 0; m1_req_addr = 0; m1_req_wdata = 0;
    e_valid = 0; e_wr = 0; e_addr = 0; e_wdata = 0; f_valid = 0; f_addr = 0;
    do_reset();

    // Idle: nothing moves for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle", {25'd0, sel, wr, m0_req_ready, m1_req_ready}, 32'd0);
      chk("idle_rsp", {wdata, 14'd0, m0_rsp_valid, m1_rsp_valid}, 32'd0);
    end

    txn(1'b0, 1'b1, 2'd2, 16'hBEEF, 4'b0100, 16'h0000);
    txn(1'b1, 1'b0, 2'd2, 16'h0000, 4'b0100, 16'hBEEF);
    txn(1'b1, 1'b0, 2'd0, 16'h0007, 4'b0001, 16'h1111);
    txn(1'b0, 1'b1, 2'd3, 16'h1234, 4'b1000, 16'h0000);
    txn(1'b0, 1'b0, 2'd3, 16'h0000, 4'b1000, 16'h1234);
    txn(1'b0, 1'b0, 2'd1, 16'h0000, 4'b0010, 16'h2222);

    // Valid withdrawn before the edge is never granted.
    @(negedge clk);
    m1_req_valid = 1'b1; m1_req_addr = 2'd1;
    #1 chk("withdraw_ready", {31'd0, m1_req_ready}, 32'd1);
    #1 m1_req_valid = 1'b0;
    @(negedge clk);
    chk("withdraw_nogrant", {28'd0, sel}, 32'd0);
    repeat (2) @(negedge clk);
    chk("withdraw_norsp", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);

    // Contention from reset with both valid continuously.
    do_reset();
    m0_req_valid = 1'b1; m0_req_wr = 1'b0; m0_req_addr = 2'd0;
    m1_req_valid = 1'b1; m1_req_wr = 1'b0; m1_req_addr = 2'd1;
    ng = 0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      #1;
      if (m0_req_ready || m1_req_ready) begin
        chk("both_ready", {31'd0, m0_req_ready & m1_req_ready}, 32'd0);
        chk("grant", {31'd0, m1_req_ready}, exp_g[ng]);
        ng++;
      end
      @(negedge clk);
    end
    chk("grant_count", ng, 32'd4);
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during ACCESS aborts the transaction.
    m0_req_valid = 1'b1; m0_req_wr = 1'b0; m0_req_addr = 2'd1;
    @(negedge clk);
    m0_req_valid = 1'b0;
    chk("abort_access", {28'd0, sel}, 32'b0010);
    #2 rstn = 1'b0;
    #1 chk("abort_async", {27'd0, sel, wr}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_norsp", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
    end
    txn(1'b1, 1'b0, 2'd2, 16'h0000, 4'b0100, 16'hBEEF);

    // Out-of-range read on the NREG=3 instance.
    @(negedge clk);
    e_valid = 1'b1; e_wr = 1'b0; e_addr = 2'd3;
    #1 chk("err_ready", {31'd0, e_ready}, 32'd1);
    @(negedge clk);
    e_valid = 1'b0;
    chk("err_access", {28'd0, e_sel, e_bus_wr}, 32'd0);
    @(negedge clk);
    chk("err_rsp", {14'd0, e_rsp_valid, e_err, e_rsp_rdata}, {14'd0, 1'b1, 1'b1, 16'h0});
    chk("err_other", {15'd0, f_rsp_valid, f_rsp_rdata}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
